// File: rtl/m68k_bus_pkg.sv
// Shared definitions for the 68000 bus responder and the master-side logic.
// Holds the FSM state encoding, the byte-lane mask type and synchronizer depth.
package m68k_bus_pkg;

  localparam int SYNC_STAGES = 2;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    ACK,
    NEGATE,
    IGNORE
  } bus_state_e;

  // Bit 1 selects the upper lane D[15:8], bit 0 the lower lane D[7:0].
  typedef logic [1:0] byte_mask_t;

endpackage

// File: rtl/m68k_sync.sv
// N-bit multi-flop synchronizer for asynchronous bus strobes into the clk domain.
// Every stage resets to RST_VAL so strobes start out deasserted.
module m68k_sync
  import m68k_bus_pkg::*;
#(
  parameter int           W       = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d_in,
  output logic [W-1:0] d_sync
);

  (* ASYNC_REG = "TRUE" *) logic [W-1:0] stage_q [SYNC_STAGES];
  logic [W-1:0] stage_d [SYNC_STAGES];

  always_comb begin
    stage_d[0] = d_in;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        stage_q[i] <= RST_VAL;
      end
    end else begin
      stage_q <= stage_d;
    end
  end

  assign d_sync = stage_q[SYNC_STAGES-1];

endmodule

// File: rtl/m68k_bus_responder.sv
// MC68000 bus target: decodes asynchronous bus cycles into a 16-bit register
// bank and acknowledges with nDTACK after WAIT_CYCLES system clocks.
module m68k_bus_responder
  import m68k_bus_pkg::*;
#(
  parameter logic [23:0] BASE_ADDR   = 24'hE80000,
  parameter int          REG_AW      = 4,
  parameter int          WAIT_CYCLES = 2
) (
  input  logic        SYS_CLK,
  input  logic        nRESET,
  input  logic [23:1] A_IN,
  input  logic [15:0] D_IN,
  output logic [15:0] D_OUT,
  output logic        D_OE,
  input  logic        RnW_IN,
  input  logic        nAS_IN,
  input  logic        nUDS_IN,
  input  logic        nLDS_IN,
  output logic        nDTACK_OUT,
  output logic        nDTACK_OE,
  output logic        DOORBELL,
  output logic        BUSY
);

  localparam int NREGS = 1 << REG_AW;
  localparam int CW    = 4;
  localparam logic [REG_AW-1:0] TOP_IDX = '1;

  logic as_s, uds_s, lds_s, rnw_s;

  m68k_sync #(
    .W       (4),
    .RST_VAL (4'b1111)
  ) u_sync (
    .clk    (SYS_CLK),
    .rst_n  (nRESET),
    .d_in   ({nAS_IN, nUDS_IN, nLDS_IN, RnW_IN}),
    .d_sync ({as_s, uds_s, lds_s, rnw_s})
  );

  bus_state_e        state_q, state_d;
  logic [REG_AW-1:0] idx_q, idx_d;
  logic              rnw_q, rnw_d;
  byte_mask_t        mask_q, mask_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [15:0]       d_out_q, d_out_d;
  logic              doorbell_q, doorbell_d;
  logic [15:0]       regs_q [NREGS];
  logic [15:0]       regs_d [NREGS];

  logic              strobe;
  logic              hit;
  logic [REG_AW-1:0] a_idx;

  assign strobe = !as_s && (!uds_s || !lds_s);
  assign hit    = (A_IN[23:REG_AW+1] == BASE_ADDR[23:REG_AW+1]);
  assign a_idx  = A_IN[REG_AW:1];

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    rnw_d      = rnw_q;
    mask_d     = mask_q;
    cnt_d      = cnt_q;
    d_out_d    = d_out_q;
    doorbell_d = 1'b0;
    regs_d     = regs_q;

    case (state_q)
      IDLE: begin
        if (strobe) begin
          if (hit) begin
            idx_d   = a_idx;
            rnw_d   = rnw_s;
            mask_d  = {~uds_s, ~lds_s};
            cnt_d   = CW'(WAIT_CYCLES);
            // Read data is launched here so it is stable for the whole WAIT phase.
            if (rnw_s) begin
              d_out_d = regs_q[a_idx];
            end
            state_d = WAIT;
          end else begin
            state_d = IGNORE;
          end
        end
      end
      WAIT: begin
        if (as_s) begin
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          state_d = ACK;
          if (!rnw_q) begin
            if (mask_q[1]) regs_d[idx_q][15:8] = D_IN[15:8];
            if (mask_q[0]) regs_d[idx_q][7:0]  = D_IN[7:0];
            doorbell_d = (idx_q == TOP_IDX);
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ACK: begin
        if (as_s) state_d = NEGATE;
      end
      NEGATE: begin
        state_d = IDLE;
      end
      IGNORE: begin
        if (as_s) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge SYS_CLK) begin
    if (!nRESET) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      rnw_q      <= 1'b0;
      mask_q     <= '0;
      cnt_q      <= '0;
      d_out_q    <= '0;
      doorbell_q <= 1'b0;
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      rnw_q      <= rnw_d;
      mask_q     <= mask_d;
      cnt_q      <= cnt_d;
      d_out_q    <= d_out_d;
      doorbell_q <= doorbell_d;
      regs_q     <= regs_d;
    end
  end

  assign BUSY       = (state_q != IDLE);
  assign nDTACK_OUT = (state_q != ACK);
  assign nDTACK_OE  = (state_q == ACK) || (state_q == NEGATE);
  assign D_OE       = rnw_q && ((state_q == WAIT) || (state_q == ACK));
  assign D_OUT      = d_out_q;
  assign DOORBELL   = doorbell_q;

endmodule
